debounce_arbiter: RTL and testbench
===================================

Name: debounce_arbiter

Overview:
Shares one debounce timer among N_BUTTONS raw, active-low push-buttons. Press edges are queued as per-button pending flags. A round-robin arbiter grants the shared timer to one pending button at a time. After the debounce window the granted button is re-sampled: a confirmed press produces a one-cycle pulse, and a glitch is counted as a reject. The block sits between board buttons and the LED/counter datapaths, replacing a per-button debounce FSM and counter.

Parameters:
N_BUTTONS, 4, number of button inputs (2..16)
ID_W, 2, width of grant_id; must satisfy 2**ID_W >= N_BUTTONS
DEBOUNCE_CYCLES, 480000, debounce window in clk cycles (>= 2)
CNT_W, 20, debounce timer width; must hold DEBOUNCE_CYCLES-1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_n  input  N_BUTTONS  raw buttons, active-low, asynchronous to clk
enable  input  1  1 = arbiter may issue new grants
press_pulse  output  N_BUTTONS  registered; one-cycle pulse per confirmed press, at most one bit high
busy  output  1  high whenever the shared timer is granted (state != IDLE)
grant_id  output  ID_W  index of the button currently or last granted
reject_count  output  8  saturating count of presses rejected at sample time
pending  output  N_BUTTONS  queued unserviced press edges (debug)

Behaviour:
- Reset (async, rst=1), all outputs and state cleared:
  - press_pulse=0, busy=0, grant_id=0, reject_count=0, pending=0.
  - Timer=0, state=IDLE, last_grant=N_BUTTONS-1, so button 0 has first priority.
  - Synchronizer and previous-level flops reset to 1 (released).
- Synchronizer: each btn_n bit passes through 2 flops giving lvl[i], then 1 more flop giving lvl_d[i]. press_edge[i] = lvl_d[i] & ~lvl[i].
- Pending:
  - Set: pending[i] is set on press_edge[i].
  - Cleared: pending[i] is cleared on the edge that grants i.
  - Ignored edges: a press_edge on the button currently granted (state WAIT or SAMPLE) is treated as bounce and not queued.
  - Collision: if an edge and the grant of the same button coincide in IDLE, the grant wins and pending ends at 0.
- FSM states: IDLE, WAIT, SAMPLE.
  - IDLE: if enable=1 and pending!=0, select the first set bit searching from (last_grant+1) mod N_BUTTONS upward with wrap. Then grant_id <= sel, timer <= 0, go to WAIT. Otherwise stay.
  - WAIT: timer increments by 1 per cycle. When timer == DEBOUNCE_CYCLES-1, go to SAMPLE. Timer never wraps.
  - SAMPLE: if lvl[grant_id]==0, press_pulse[grant_id] <= 1 for exactly one cycle. Otherwise reject_count <= reject_count+1, holding at 255. In both cases last_grant <= grant_id and go to IDLE.
- press_pulse is 0 in every cycle other than the one following SAMPLE.
- busy: combinational from state, high in WAIT and SAMPLE.
- grant_id holds its value in IDLE.
- Latency, uncontended, enable=1: take the first clk edge that samples btn_n[i] low as edge 0. pending[i] rises after edge 2; state WAIT after edge 3; SAMPLE after edge DEBOUNCE_CYCLES+3; press_pulse[i] high between edges DEBOUNCE_CYCLES+4 and DEBOUNCE_CYCLES+5.
- Back-to-back grants: the pulse cycle is also the IDLE cycle, so the next grant is issued on the following edge when pending!=0.
- enable=0:
  - New press edges still set pending.
  - A grant already in WAIT/SAMPLE completes normally.
  - No new grant is issued until enable=1.
- Reset mid-operation: reset aborts any WAIT/SAMPLE immediately, with no pulse and no reject counted, and drops all pending flags.
- Arithmetic: the timer is CNT_W-bit unsigned. reject_count is 8-bit saturating and never wraps to 0.

Test Plan (DEBOUNCE_CYCLES=16, N_BUTTONS=4):
1. Single clean press: hold btn_n[2] low 40 cycles -> press_pulse=4'b0100 for exactly one cycle, after edge 20; busy high after edges 3..19; reject_count=0.
2. Glitch: btn_n[1] low for 3 cycles, then high -> busy for 17 cycles, no press_pulse, reject_count=1. Repeat 300 glitches -> reject_count saturates at 255.
3. Round-robin contention: press buttons 0,1,3 simultaneously, held 100 cycles -> pulses in order 0,1,3, one cycle each, separated by 18 cycles; grant_id sequence 0,1,3.
4. Bounce during wait: btn_n[0] toggles 5 times within the first 10 cycles, then stays low -> exactly one pulse on bit 0 and pending[0]=0 afterwards. Release bounce (toggling, then settled high) -> at most rejects, no second pulse.
5. enable gating: enable=0, press buttons 2 and 3 -> pending=4'b1100, busy=0. Raise enable -> button 2 serviced, then button 3.
6. Reset mid-WAIT: assert rst at timer=8 -> busy, pending, press_pulse and reject_count all 0 immediately. After release, no pulse unless a new press edge occurs.

Source files
------------

// File: rtl/debounce_arbiter.sv
// Debounces N_BUTTONS active-low push-buttons with one shared timer.
// Press edges are queued and serviced round-robin. Each grant ends in either a confirmed pulse or a counted reject.
module debounce_arbiter #(
    parameter int N_BUTTONS       = 4,
    parameter int ID_W            = 2,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int CNT_W           = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] btn_n,
    input  logic                 enable,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic [7:0]           reject_count,
    output logic [N_BUTTONS-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t                 state_r, state_next_s;
    logic [N_BUTTONS-1:0]   sync1_r, lvl_r, lvl_d_r, press_edge_s;
    logic [CNT_W-1:0]       timer_r, timer_next_s;
    logic [ID_W-1:0]        last_grant_r, last_next_s, grant_next_s, sel_s;
    logic                   sel_valid_s;
    logic [N_BUTTONS-1:0]   pending_next_s, pulse_next_s, clear_mask_s, ignore_mask_s;
    logic [7:0]             reject_next_s;

    // Scans from the button after last toward last itself; the nearest request wins.
    function automatic logic [ID_W:0] rr_pick(input logic [N_BUTTONS-1:0] req,
                                              input logic [ID_W-1:0]      last);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = N_BUTTONS; k >= 1; k--) begin
            idx = (int'(last) + k) % N_BUTTONS;
            if (req[idx[ID_W-1:0]]) begin
                res = {1'b1, idx[ID_W-1:0]};
            end
        end
        return res;
    endfunction

    assign press_edge_s = lvl_d_r & ~lvl_r;
    assign busy         = (state_r != IDLE);

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= '1;
            lvl_r   <= '1;
            lvl_d_r <= '1;
        end else begin
            sync1_r <= btn_n;
            lvl_r   <= sync1_r;
            lvl_d_r <= lvl_r;
        end
    end

    // Next-state, grant selection, pending bookkeeping and sample decision.
    always_comb begin
        state_next_s  = state_r;
        timer_next_s  = timer_r;
        grant_next_s  = grant_id;
        last_next_s   = last_grant_r;
        reject_next_s = reject_count;
        pulse_next_s  = '0;
        clear_mask_s  = '0;
        ignore_mask_s = '0;
        {sel_valid_s, sel_s} = rr_pick(pending, last_grant_r);
        case (state_r)
            IDLE: begin
                if (enable && sel_valid_s) begin
                    state_next_s         = WAIT;
                    timer_next_s         = '0;
                    grant_next_s         = sel_s;
                    clear_mask_s[sel_s]  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                ignore_mask_s[grant_id] = 1'b1;
                if (timer_r == TIMER_LAST) begin
                    state_next_s = SAMPLE;
                end else begin
                    timer_next_s = timer_r + CNT_W'(1);
                end
            end
            SAMPLE: begin
                // Further edges on the serviced button are bounce until it is released from service.
                ignore_mask_s[grant_id] = 1'b1;
                if (!lvl_r[grant_id]) begin
                    pulse_next_s[grant_id] = 1'b1;
                end else if (reject_count != 8'hFF) begin
                    reject_next_s = reject_count + 8'd1;
                end else begin
                    reject_next_s = reject_count;
                end
                last_next_s  = grant_id;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        pending_next_s = (pending | (press_edge_s & ~ignore_mask_s)) & ~clear_mask_s;
    end

    // Arbiter state, timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            timer_r      <= '0;
            last_grant_r <= ID_W'(N_BUTTONS - 1);
            grant_id     <= '0;
            reject_count <= 8'd0;
            press_pulse  <= '0;
            pending      <= '0;
        end else begin
            state_r      <= state_next_s;
            timer_r      <= timer_next_s;
            last_grant_r <= last_next_s;
            grant_id     <= grant_next_s;
            reject_count <= reject_next_s;
            press_pulse  <= pulse_next_s;
            pending      <= pending_next_s;
        end
    end

endmodule

// File: tb/tb_debounce_arbiter.sv
// Randomized and directed bench for debounce_arbiter with a transaction-level reference model.
module tb_debounce_arbiter;

    localparam int NB = 4;
    localparam int DC = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_n = 4'hF;
    logic          enable = 1'b1;
    logic [NB-1:0] press_pulse;
    logic          busy;
    logic [1:0]    grant_id;
    logic [7:0]    reject_count;
    logic [NB-1:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    debounce_arbiter #(
        .N_BUTTONS(NB), .ID_W(2), .DEBOUNCE_CYCLES(DC), .CNT_W(5)
    ) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .enable(enable),
        .press_pulse(press_pulse), .busy(busy), .grant_id(grant_id),
        .reject_count(reject_count), .pending(pending)
    );

    always #5 clk = ~clk;

    // Model: b1/b2/b3 are btn_n as seen 1/2/3 edges ago; a grant taken at edge g is decided at edge g+DC+1.
    typedef struct packed {
        logic [3:0] pend;
        logic [3:0] pulse;
        logic [3:0] b1;
        logic [3:0] b2;
        logic [3:0] b3;
        logic       act;
        logic [1:0] grant;
        logic [1:0] last;
        int         gedge;
        int         rej;
        int         cyc;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.b1 = 4'hF;
        r.b2 = 4'hF;
        r.b3 = 4'hF;
        r.last = 2'(NB - 1);
        return r;
    endfunction

    function automatic model_t step(model_t cur, logic [3:0] btn, logic en);
        model_t     n;
        logic [3:0] edges;
        logic [3:0] clr;
        logic       found;
        int         idx;
        n = cur;
        edges = cur.b3 & ~cur.b2;
        clr = 4'h0;
        found = 1'b0;
        n.pulse = 4'h0;
        if (cur.act) begin
            edges[cur.grant] = 1'b0;
            if (cur.cyc == cur.gedge + DC + 1) begin
                if (!cur.b2[cur.grant]) n.pulse[cur.grant] = 1'b1;
                else if (cur.rej < 255) n.rej = cur.rej + 1;
                n.last = cur.grant;
                n.act = 1'b0;
            end
        end else if (en && cur.pend != 4'h0) begin
            for (int k = 1; k <= NB; k++) begin
                idx = (int'(cur.last) + k) % NB;
                if (!found && cur.pend[idx[1:0]]) begin
                    found = 1'b1;
                    n.grant = idx[1:0];
                end
            end
            n.act = 1'b1;
            n.gedge = cur.cyc;
            clr[n.grant] = 1'b1;
        end
        n.pend = (cur.pend | edges) & ~clr;
        n.b3 = cur.b2;
        n.b2 = cur.b1;
        n.b1 = btn;
        n.cyc = cur.cyc + 1;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= step(m, btn_n, enable);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("pulse_vs_model",   32'(press_pulse),  32'(m.pulse));
        check("busy_vs_model",    32'(busy),         32'(m.act));
        check("grant_vs_model",   32'(grant_id),     32'(m.grant));
        check("reject_vs_model",  32'(reject_count), 32'(m.rej));
        check("pending_vs_model", 32'(pending),      32'(m.pend));
    end

    int pulse_ids[$];
    int pulse_cyc[$];
    int grant_seq[$];

    task automatic collect(input int ncyc);
        logic prev_busy;
        pulse_ids.delete();
        pulse_cyc.delete();
        grant_seq.delete();
        prev_busy = busy;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                if (press_pulse[i]) begin
                    pulse_ids.push_back(i);
                    pulse_cyc.push_back(c);
                end
            end
            if (busy && !prev_busy) grant_seq.push_back(int'(grant_id));
            prev_busy = busy;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic glitch(output int busy_n, output int pulse_n);
        busy_n = 0;
        pulse_n = 0;
        btn_n[1] = 1'b0;
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (press_pulse != 4'h0) pulse_n++;
            if (c == 2) btn_n[1] = 1'b1;
        end
    endtask

    initial begin
        int bn, pn, cnt;
        repeat (3) @(negedge clk);
        check("reset_pulse",   32'(press_pulse),  32'h0);
        check("reset_busy",    32'(busy),         32'h0);
        check("reset_grant",   32'(grant_id),     32'h0);
        check("reset_reject",  32'(reject_count), 32'h0);
        check("reset_pending", 32'(pending),      32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single clean press on button 2: literal latency expectations.
        btn_n = 4'b1011;
        for (int e = 0; e < 25; e++) begin
            @(negedge clk);
            check("t1_pending", 32'(pending),     (e == 2) ? 32'h4 : 32'h0);
            check("t1_busy",    32'(busy),        (e >= 3 && e <= 19) ? 32'h1 : 32'h0);
            check("t1_pulse",   32'(press_pulse), (e == 20) ? 32'h4 : 32'h0);
            check("t1_model_busy",  32'(m.act),   (e >= 3 && e <= 19) ? 32'h1 : 32'h0);
            check("t1_model_pulse", 32'(m.pulse), (e == 20) ? 32'h4 : 32'h0);
        end
        btn_n = 4'hF;
        repeat (5) @(negedge clk);
        check("t1_reject", 32'(reject_count), 32'h0);

        // Glitches: one reject, then saturation.
        glitch(bn, pn);
        check("t2_busy_cycles", 32'(bn), 32'd17);
        check("t2_no_pulse",    32'(pn), 32'd0);
        check("t2_reject_one",  32'(reject_count), 32'd1);
        for (int g = 1; g < 300; g++) glitch(bn, pn);
        check("t2_reject_sat", 32'(reject_count), 32'd255);

        // Round-robin contention from a fresh reset.
        do_reset();
        btn_n = 4'b0100;
        collect(100);
        check("t3_pulse_count", 32'(pulse_ids.size()), 32'd3);
        check("t3_grant_count", 32'(grant_seq.size()), 32'd3);
        if (pulse_ids.size() == 3) begin
            check("t3_order0", 32'(pulse_ids[0]), 32'd0);
            check("t3_order1", 32'(pulse_ids[1]), 32'd1);
            check("t3_order2", 32'(pulse_ids[2]), 32'd3);
            check("t3_gap01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd18);
            check("t3_gap12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd18);
        end
        if (grant_seq.size() == 3) begin
            check("t3_grant2", 32'(grant_seq[2]), 32'd3);
        end
        btn_n = 4'hF;
        repeat (5) @(negedge clk);

        // Press bounce then release bounce on button 0.
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            btn_n[0] = (c < 10) ? logic'((c / 2) % 2) : 1'b0;
            @(negedge clk);
            if (press_pulse[0]) cnt++;
        end
        check("t4_one_pulse", 32'(cnt), 32'd1);
        check("t4_pending0",  32'(pending[0]), 32'd0);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            btn_n[0] = (c < 10) ? logic'(((c / 2) % 2) == 0) : 1'b1;
            @(negedge clk);
            if (press_pulse[0]) cnt++;
        end
        check("t4_release_no_pulse", 32'(cnt), 32'd0);
        check("t4_release_pending",  32'(pending), 32'h0);

        // Enable gating.
        enable = 1'b0;
        btn_n = 4'b0011;
        repeat (10) @(negedge clk);
        check("t5_pending", 32'(pending), 32'hC);
        check("t5_idle",    32'(busy),    32'h0);
        enable = 1'b1;
        collect(60);
        check("t5_pulse_count", 32'(pulse_ids.size()), 32'd2);
        if (pulse_ids.size() == 2) begin
            check("t5_first",  32'(pulse_ids[0]), 32'd2);
            check("t5_second", 32'(pulse_ids[1]), 32'd3);
        end
        btn_n = 4'hF;
        repeat (5) @(negedge clk);

        // Reset in the middle of the debounce window.
        btn_n[1] = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_busy_before", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        btn_n[1] = 1'b1;
        #1;
        check("t6_busy",   32'(busy),         32'h0);
        check("t6_pending",32'(pending),      32'h0);
        check("t6_pulse",  32'(press_pulse),  32'h0);
        check("t6_reject", 32'(reject_count), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        collect(40);
        check("t6_no_pulse", 32'(pulse_ids.size()), 32'd0);

        // Random buttons and enable, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 15) == 0) btn_n[i] = ~btn_n[i];
            end
            enable = ($urandom_range(0, 7) != 0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
